// File: rtl/binary_add_pkg.sv
// binary_add_pkg -- shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : values of the per-beat `sub` control bit.
//   sat_hi / sat_lo     : saturation limits for a given width and signedness,
//                         returned zero-extended in SAT_MAX_W bits.
//   cfg_ok              : parameter legality check used at elaboration.
package binary_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int SAT_MAX_W = 64;

  // Largest representable value: 2^(w-1)-1 when signed, 2^w-1 when unsigned.
  function automatic logic [SAT_MAX_W-1:0] sat_hi(input int unsigned width, input bit sgn);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < int'(width)) r[i] = 1'b1;
    end
    if (sgn && width >= 1) r[width-1] = 1'b0;
    return r;
  endfunction

  // Smallest representable value: -2^(w-1) when signed, 0 when unsigned.
  function automatic logic [SAT_MAX_W-1:0] sat_lo(input int unsigned width, input bit sgn);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    if (sgn && width >= 1) r[width-1] = 1'b1;
    return r;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/binary_add_stage.sv
// binary_add_stage -- one CW-bit chunk of the carry chain plus its slot register.
//   Adds chunk IDX (bits IDX*CW .. IDX*CW+CW-1) of in_a/in_b with in_c and
//   writes it into the partial result in_s.  Operands, mode and the partial
//   result all travel with the beat so later stages see their own chunks.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   en                   : global advance enable (0 freezes the slot)
//   in_valid / in_ready  : upstream handshake
//   in_a, in_b, in_sub   : operands (b already inverted for subtract) and mode
//   in_s, in_c           : partial result so far and carry into this chunk
//   out_valid / out_ready: downstream handshake
//   out_a .. out_c       : registered beat (out_c = carry out of this chunk)
// Handshake: a beat moves across a boundary on a clock edge where valid and
// ready are both 1; ready never depends on valid of the same boundary.
module binary_add_stage #(
  parameter int WIDTH = 16,
  parameter int CW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sub,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c
);

  localparam int LO = IDX * CW;

  logic [CW:0]      chunk_sum;
  logic [WIDTH-1:0] s_next;

  assign chunk_sum = {1'b0, in_a[LO +: CW]} + {1'b0, in_b[LO +: CW]} + {{CW{1'b0}}, in_c};

  always_comb begin
    s_next = in_s;
    s_next[LO +: CW] = chunk_sum[CW-1:0];
  end

  // The slot can take a beat when empty or when its own beat leaves this cycle.
  assign in_ready = en & (~out_valid | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sub   <= 1'b0;
      out_s     <= '0;
      out_c     <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_a     <= in_a;
      out_b     <= in_b;
      out_sub   <= in_sub;
      out_s     <= s_next;
      out_c     <= chunk_sum[CW];
    end else if (en && out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/binary_add_pipe.sv
// binary_add_pipe -- pipelined two's-complement adder/subtractor.
//   The WIDTH-bit carry chain is cut into STAGES chunks of CW = WIDTH/STAGES
//   bits; stage k adds chunk k with the carry registered by stage k-1.
//   Latency is STAGES cycles, throughput one beat per cycle, bubbles collapse.
// Parameters: WIDTH (multiple of STAGES), STAGES (>= 1), SIGNED (1 = signed
//   overflow rule, 0 = unsigned rule).
// Optional build macro BINARY_ADD_SATURATE_EN: when defined, s is clamped to
//   the representable range whenever ovf=1 (carry/ovf still describe the raw
//   result); when undefined s wraps modulo 2^WIDTH.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : global advance enable; 0 freezes all stages
//   in_valid / in_ready : operand handshake (a, b, sub)
//   out_valid / out_ready: result handshake (s, carry, ovf)
//   carry               : add = carry out of MSB, sub = 1 when no borrow
//   ovf                 : overflow under the SIGNED rule
// Handshake: a beat transfers on a rising edge where valid & ready are both 1;
// the producer must hold in_valid, a, b and sub stable while in_ready=0.
module binary_add_pipe
  import binary_add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("binary_add_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Boundary k sits in front of stage k; boundary STAGES is the output port.
  logic [STAGES:0] v_p;
  logic [STAGES:0] r_p;
  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] b_p   [STAGES+1];
  logic [WIDTH-1:0] s_p   [STAGES+1];
  logic             sub_p [STAGES+1];
  logic             c_p   [STAGES+1];

  // Subtract is a + ~b + 1: invert b once here and seed the chain with 1.
  assign v_p[0]   = in_valid;
  assign a_p[0]   = a;
  assign b_p[0]   = (sub == MODE_SUB) ? ~b : b;
  assign sub_p[0] = sub;
  assign s_p[0]   = '0;
  assign c_p[0]   = (sub == MODE_SUB);

  assign r_p[STAGES] = out_ready;
  assign in_ready    = r_p[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    binary_add_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_p[k]),
      .in_ready  (r_p[k]),
      .in_a      (a_p[k]),
      .in_b      (b_p[k]),
      .in_sub    (sub_p[k]),
      .in_s      (s_p[k]),
      .in_c      (c_p[k]),
      .out_valid (v_p[k+1]),
      .out_ready (r_p[k+1]),
      .out_a     (a_p[k+1]),
      .out_b     (b_p[k+1]),
      .out_sub   (sub_p[k+1]),
      .out_s     (s_p[k+1]),
      .out_c     (c_p[k+1])
    );
  end

  logic [WIDTH-1:0] s_raw;
  logic             a_msb;
  logic             b_msb;
  logic             sub_last;
  logic             carry_msb_in;
  logic             unused_low_operands;

  assign s_raw    = s_p[STAGES];
  assign a_msb    = a_p[STAGES][WIDTH-1];
  assign b_msb    = b_p[STAGES][WIDTH-1];
  assign sub_last = sub_p[STAGES];
  assign unused_low_operands = ^{a_p[STAGES][WIDTH-2:0], b_p[STAGES][WIDTH-2:0]};

  // The MSB sum bit is a ^ b ^ cin, so the carry into the MSB falls out of the
  // registered operand and result MSBs without keeping an extra flop.
  assign carry_msb_in = a_msb ^ b_msb ^ s_raw[WIDTH-1];

  assign out_valid = v_p[STAGES];
  assign carry     = c_p[STAGES];
  assign ovf       = (SIGNED != 0) ? (carry ^ carry_msb_in)
                                   : (sub_last ? ~carry : carry);

`ifdef BINARY_ADD_SATURATE_EN
  localparam logic [SAT_MAX_W-1:0] SAT_HI_FULL = sat_hi(WIDTH, SIGNED != 0);
  localparam logic [SAT_MAX_W-1:0] SAT_LO_FULL = sat_lo(WIDTH, SIGNED != 0);
  localparam logic [WIDTH-1:0]     SAT_HI      = SAT_HI_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_LO      = SAT_LO_FULL[WIDTH-1:0];

  // Signed overflow only happens when both effective operands share a sign,
  // so a's MSB tells positive from negative overflow.  Unsigned: add runs off
  // the top, subtract runs off the bottom.
  logic clamp_hi;
  assign clamp_hi = (SIGNED != 0) ? ~a_msb : ~sub_last;
  assign s        = ovf ? (clamp_hi ? SAT_HI : SAT_LO) : s_raw;
`else
  assign s = s_raw;
`endif

endmodule

// File: tb/tb_binary_add_pipe.sv
module tb_binary_add_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit signed and unsigned instances share their inputs.
  logic        en = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, carry, ovf;
  logic [15:0] s;
  logic        u_in_ready, u_out_valid, u_carry, u_ovf;
  logic [15:0] u_s;

  // 5-bit single-stage instance for the exhaustive sweep.
  logic       en5 = 1'b1, in_valid5 = 1'b0, sub5 = 1'b0, out_ready5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       in_ready5, out_valid5, carry5, ovf5;
  logic [4:0] s5;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic [6:0]  exp5_q[$];

  binary_add_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry(carry), .ovf(ovf)
  );

  binary_add_pipe #(.WIDTH(16), .STAGES(2), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(u_out_valid), .out_ready(out_ready),
    .s(u_s), .carry(u_carry), .ovf(u_ovf)
  );

  binary_add_pipe #(.WIDTH(5), .STAGES(1), .SIGNED(1)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .sub(sub5), .out_valid(out_valid5), .out_ready(out_ready5),
    .s(s5), .carry(carry5), .ovf(ovf5)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [15:0] av, input logic [15:0] bv,
                            input logic sv, output bit ok);
    int guard;
    guard = 0;
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = out_valid;
  endtask

  // Pops exp_q as results transfer; returns how many arrived within budget.
  task automatic collect(input int n, output int got);
    int guard;
    logic [15:0] e;
    got = 0; guard = 0;
    while (got < n && guard < 40) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (s !== e) $display("FAIL collect_s[%0d]: got %h expected %h", got, s, e);
        else n_pass++;
        got++;
      end
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (s !== 16'h0) $display("FAIL reset_s: got %h expected 0000", s); else n_pass++;
    n_checks++; if ({carry, ovf} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {carry, ovf}); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_in_flight;
    bit ok1, ok2, seen;
    out_ready = 1'b1;
    drive_beat(16'd1, 16'd1, 1'b0, ok1);
    drive_beat(16'd2, 16'd2, 1'b0, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL flight_accept: got %b%b expected 11", ok1, ok2); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL flight_before_rst: got %b expected 1", out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flight_rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (s !== 16'h0) $display("FAIL flight_rst_s: got %h expected 0000", s); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flight_rst_in_ready: got %b expected 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flight_release_in_ready: got %b expected 1", in_ready); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flight_stale_beat: got %b expected 0", seen); else n_pass++;
  endtask

  task automatic test_overflow;
    bit ok;
    logic [15:0] e_s;
`ifdef BINARY_ADD_SATURATE_EN
    e_s = 16'h7FFF;
`else
    e_s = 16'h8000;
`endif
    out_ready = 1'b1;
    drive_beat(16'h7FFF, 16'h0001, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL ovf_accept: got 0 expected 1"); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_latency_early: got %b expected 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ovf_latency: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (s !== e_s) $display("FAIL ovf_s: got %h expected %h", s, e_s); else n_pass++;
    n_checks++; if ({carry, ovf} !== 2'b01) $display("FAIL ovf_flags: got %b expected 01", {carry, ovf}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_consumed: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_chunk_carry;
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic        vs [5];
    logic [15:0] es [5];
    logic [1:0]  ef [5];
    logic [15:0] e_us;
    bit ok;
    va = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h0000, 16'h8000};
    vb = '{16'h0001, 16'h0001, 16'h0003, 16'h0001, 16'h0001};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es = '{16'h0100, 16'h0000, 16'h0002, 16'hFFFF, 16'h7FFF};
    ef = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b11};
`ifdef BINARY_ADD_SATURATE_EN
    es[4] = 16'h8000;
    e_us  = 16'h0000;
`else
    e_us  = 16'hFFFF;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(va[i], vb[i], vs[i], ok);
      wait_out(ok);
      n_checks++; if (!ok) $display("FAIL chunk_timeout[%0d]: got no result expected one", i); else n_pass++;
      n_checks++; if (s !== es[i]) $display("FAIL chunk_s[%0d]: got %h expected %h", i, s, es[i]); else n_pass++;
      n_checks++; if ({carry, ovf} !== ef[i]) $display("FAIL chunk_flags[%0d]: got %b expected %b", i, {carry, ovf}, ef[i]); else n_pass++;
      if (i == 3) begin
        n_checks++; if (u_out_valid !== 1'b1) $display("FAIL unsigned_valid: got %b expected 1", u_out_valid); else n_pass++;
        n_checks++; if (u_s !== e_us) $display("FAIL unsigned_s: got %h expected %h", u_s, e_us); else n_pass++;
        n_checks++; if ({u_carry, u_ovf} !== 2'b01) $display("FAIL unsigned_flags: got %b expected 01", {u_carry, u_ovf}); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure;
    bit ok1, ok2, ok3, ok4;
    int got;
    out_ready = 1'b0;
    #1;
    drive_beat(16'd1, 16'd2, 1'b0, ok1);
    drive_beat(16'd3, 16'd4, 1'b0, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL bp_accept: got %b%b expected 11", ok1, ok2); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); else n_pass++;
    a = 16'd5; b = 16'd6; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_hold: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_hold: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (s !== 16'd3) $display("FAIL bp_s_hold: got %h expected 0003", s); else n_pass++;
    exp_q = '{16'd3, 16'd7, 16'd11, 16'd15};
    out_ready = 1'b1;
    #1;
    fork
      begin
        drive_beat(16'd5, 16'd6, 1'b0, ok3);
        drive_beat(16'd7, 16'd8, 1'b0, ok4);
      end
      collect(4, got);
    join
    n_checks++; if (got != 4) $display("FAIL bp_count: got %0d expected 4", got); else n_pass++;
    n_checks++; if (!(ok3 && ok4)) $display("FAIL bp_accept_late: got %b%b expected 11", ok3, ok4); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_duplicate[%0d]: got %b expected 0", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_enable_stall;
    bit ok1, ok2, ok3;
    int got;
    out_ready = 1'b1;
    #1;
    drive_beat(16'd10, 16'd20, 1'b0, ok1);
    drive_beat(16'd30, 16'd40, 1'b0, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL en_accept: got %b%b expected 11", ok1, ok2); else n_pass++;
    en = 1'b0;
    a = 16'd50; b = 16'd60; sub = 1'b0; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) $display("FAIL en_in_ready[%0d]: got %b expected 0", i, in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL en_out_valid[%0d]: got %b expected 1", i, out_valid); else n_pass++;
      n_checks++; if (s !== 16'd30) $display("FAIL en_s[%0d]: got %h expected 001e", i, s); else n_pass++;
      @(posedge clk); #1;
    end
    exp_q = '{16'd30, 16'd70, 16'd110};
    en = 1'b1;
    #1;
    fork
      drive_beat(16'd50, 16'd60, 1'b0, ok3);
      collect(3, got);
    join
    n_checks++; if (got != 3) $display("FAIL en_count: got %0d expected 3", got); else n_pass++;
    n_checks++; if (!ok3) $display("FAIL en_accept_late: got 0 expected 1"); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL en_duplicate: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_exhaustive5;
    int idx, got, cyc, av, bv, sv, full, ua, ub;
    bit acc, xf;
    logic [6:0] cur_exp, e, act;
    logic [4:0] se;
    logic ce, oe;
    idx = 0; got = 0; cyc = 0;
    in_valid5 = 1'b1;
    cur_exp = '0;
    while (got < 2048 && cyc < 20000) begin
      if (idx < 2048) begin
        av = (idx >> 5) & 31; if (av > 15) av = av - 32;
        bv = idx & 31;        if (bv > 15) bv = bv - 32;
        sv = (idx >> 10) & 1;
        a5 = 5'(av); b5 = 5'(bv); sub5 = sv[0];
        full = (sv != 0) ? av - bv : av + bv;
        ua = av & 31; ub = bv & 31;
        ce = (sv != 0) ? (ua >= ub) : ((ua + ub) >= 32);
        oe = (full > 15) || (full < -16);
        se = 5'(full);
`ifdef BINARY_ADD_SATURATE_EN
        if (oe) se = (full > 15) ? 5'd15 : 5'd16;
`endif
        cur_exp = {se, ce, oe};
      end else begin
        in_valid5 = 1'b0;
      end
      out_ready5 = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid5 && in_ready5;
      xf  = out_valid5 && out_ready5;
      if (xf) begin
        act = {s5, carry5, ovf5};
        n_checks++;
        if (exp5_q.size() == 0) begin
          $display("FAIL ex5_unexpected: got %b expected no beat", act);
        end else begin
          e = exp5_q.pop_front();
          if (act !== e) $display("FAIL ex5_beat[%0d]: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                                  got, act[6:2], act[1], act[0], e[6:2], e[1], e[0]);
          else n_pass++;
        end
        got++;
      end
      if (acc) exp5_q.push_back(cur_exp);
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    in_valid5 = 1'b0;
    n_checks++; if (got != 2048) $display("FAIL ex5_count: got %0d expected 2048", got); else n_pass++;
    n_checks++; if (exp5_q.size() != 0) $display("FAIL ex5_leftover: got %0d expected 0", exp5_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_reset_in_flight;
    test_overflow;
    test_chunk_carry;
    test_back_pressure;
    test_enable_stall;
    test_exhaustive5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
